// File: rtl/tracker_array_decoder_if.sv
// Sensor-to-steering bus for the line-tracker decoder: raw sensor vector in,
// steering code, signed position and seek/lost status out.
interface tracker_array_decoder_if #(
    parameter int unsigned N_SENSORS = 5
);
    localparam int unsigned POS_W = $clog2(N_SENSORS * N_SENSORS) + 1;

    logic [N_SENSORS-1:0]    track;
    logic [1:0]              state;
    logic signed [POS_W-1:0] position;
    logic                    seeking;
    logic                    lost;

    modport master (output track, input state, position, seeking, lost);
    modport slave  (input track, output state, position, seeking, lost);
endinterface

// File: rtl/tracker_array_decoder.sv
// N-channel line-tracker front end: synchronise, debounce, weigh the sensors and
// steer, remembering the last turn for a bounded time when the line disappears.
module tracker_array_decoder #(
    parameter int unsigned N_SENSORS    = 5,
    parameter int unsigned FILTER_LEN   = 4,
    parameter int unsigned LOST_TIMEOUT = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    tracker_array_decoder_if.slave  bus
);
    localparam int unsigned POS_W = $clog2(N_SENSORS * N_SENSORS) + 1;
    localparam int unsigned DEB_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TMR_W = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
    localparam int unsigned CNT_W = $clog2(N_SENSORS + 1);
    localparam int          HALF  = (int'(N_SENSORS) - 1) / 2;

    localparam logic [1:0] STEER_STOP  = 2'b00;
    localparam logic [1:0] STEER_RIGHT = 2'b01;
    localparam logic [1:0] STEER_LEFT  = 2'b10;
    localparam logic [1:0] STEER_FWD   = 2'b11;

    typedef enum logic [1:0] {
        ST_TRACK = 2'd0,
        ST_SEEK  = 2'd1,
        ST_LOST  = 2'd2
    } fsm_e;

    logic [N_SENSORS-1:0]    sync1_q;
    logic [N_SENSORS-1:0]    sync2_q;
    logic [N_SENSORS-1:0]    filt_q;
    logic [DEB_W-1:0]        deb_q [N_SENSORS];
    fsm_e                    fsm_q;
    logic [TMR_W-1:0]        timer_q;
    logic [1:0]              last_dir_q;
    logic [1:0]              state_q;
    logic signed [POS_W-1:0] pos_q;
    logic                    seeking_q;
    logic                    lost_q;

    logic signed [POS_W-1:0] sum_c;
    logic [CNT_W-1:0]        cnt_c;
    logic                    all_on_c;
    logic [1:0]              dir_c;

    // Two-flop synchroniser per channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.track;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= '0;
            for (int i = 0; i < int'(N_SENSORS); i++) deb_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_SENSORS); i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    deb_q[i] <= '0;
                end else if (deb_q[i] == DEB_W'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    deb_q[i]  <= '0;
                end else begin
                    deb_q[i] <= deb_q[i] + 1'b1;
                end
            end
        end
    end

    // Weighted position, active count and raw steering decision
    always_comb begin
        sum_c = '0;
        cnt_c = '0;
        for (int i = 0; i < int'(N_SENSORS); i++) begin
            if (filt_q[i]) begin
                sum_c = sum_c + POS_W'(i - HALF);
                cnt_c = cnt_c + 1'b1;
            end
        end
        all_on_c = &filt_q;
        if (all_on_c)          dir_c = STEER_STOP;
        else if (sum_c < 0)    dir_c = STEER_LEFT;
        else if (sum_c > 0)    dir_c = STEER_RIGHT;
        else                   dir_c = STEER_FWD;
    end

    // Any visible line forces TRACK from every state, so reacquire beats the timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q      <= ST_LOST;
            timer_q    <= '0;
            last_dir_q <= STEER_FWD;
            state_q    <= STEER_STOP;
            pos_q      <= '0;
            seeking_q  <= 1'b0;
            lost_q     <= 1'b1;
        end else if (cnt_c != '0) begin
            fsm_q     <= ST_TRACK;
            state_q   <= dir_c;
            pos_q     <= sum_c;
            seeking_q <= 1'b0;
            lost_q    <= 1'b0;
            if (!all_on_c) last_dir_q <= dir_c;
        end else begin
            case (fsm_q)
                ST_TRACK: begin
                    fsm_q     <= ST_SEEK;
                    timer_q   <= '0;
                    state_q   <= last_dir_q;
                    seeking_q <= 1'b1;
                    lost_q    <= 1'b0;
                end
                ST_SEEK: begin
                    if (timer_q == TMR_W'(LOST_TIMEOUT - 1)) begin
                        fsm_q     <= ST_LOST;
                        state_q   <= STEER_STOP;
                        pos_q     <= '0;
                        seeking_q <= 1'b0;
                        lost_q    <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    fsm_q     <= ST_LOST;
                    state_q   <= STEER_STOP;
                    pos_q     <= '0;
                    seeking_q <= 1'b0;
                    lost_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.state    = state_q;
    assign bus.position = pos_q;
    assign bus.seeking  = seeking_q;
    assign bus.lost     = lost_q;
endmodule
